// File: rtl/entry_pkg.sv
// rtl/entry_pkg.sv - mode encodings, default depths and saturation helper for entry_counter
package entry_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_KEY  = 2'b01;
  localparam logic [1:0] MODE_DATA = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  localparam int KEY_DEPTH_DEF  = 8;
  localparam int DATA_DEPTH_DEF = 24;

  typedef enum logic {
    ACT_STEP   = 1'b0,
    ACT_REJECT = 1'b1
  } act_e;

  // A delete is refused at zero, an insert is refused at the buffer limit.
  function automatic act_e sat_action(input logic dec, input logic at_zero, input logic at_limit);
    if (dec ? at_zero : at_limit)
      return ACT_REJECT;
    return ACT_STEP;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - keypad strobe falling-edge detector with backspace qualifier
// ENTRY_COUNTER_SYNC_EN inserts a 2-flop synchroniser ahead of the history register.
module key_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic key_press,
  input  logic backspace,
  output logic fall_evt,
  output logic bs_q
);

  logic kp_s;
  logic bs_s;

`ifdef ENTRY_COUNTER_SYNC_EN
  logic [1:0] kp_sync;
  logic [1:0] bs_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kp_sync <= '0;
      bs_sync <= '0;
    end else begin
      kp_sync <= {kp_sync[0], key_press};
      bs_sync <= {bs_sync[0], backspace};
    end
  end

  assign kp_s = kp_sync[1];
  assign bs_s = bs_sync[1];
`else
  assign kp_s = key_press;
  assign bs_s = backspace;
`endif

  logic kp_hist;
  logic bs_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kp_hist <= 1'b0;
      bs_hist <= 1'b0;
    end else begin
      kp_hist <= kp_s;
      bs_hist <= bs_s;
    end
  end

  // Backspace comes from the stage that still saw the key held, where it is guaranteed stable.
  assign fall_evt = kp_hist & ~kp_s;
  assign bs_q     = bs_hist;

endmodule

// File: rtl/entry_counter.sv
// rtl/entry_counter.sv - saturating key/data write indices driven by keypad strokes
// ENTRY_COUNTER_SYNC_EN (in key_edge_sync) selects the synchronised keypad path.
module entry_counter
  import entry_pkg::*;
#(
  parameter int DATA_DEPTH = DATA_DEPTH_DEF,
  parameter int KEY_DEPTH  = KEY_DEPTH_DEF,
  parameter int IDX_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             key_press,
  input  logic             backspace,
  input  logic             clear,
  output logic [IDX_W-1:0] key_index,
  output logic [IDX_W-1:0] data_index,
  output logic             key_full,
  output logic             data_full,
  output logic             data_empty,
  output logic             step,
  output logic             reject
);

  localparam logic [IDX_W-1:0] KEY_LIM  = IDX_W'(KEY_DEPTH);
  localparam logic [IDX_W-1:0] DATA_LIM = IDX_W'(DATA_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic fall_evt;
  logic bs_q;

  key_edge_sync u_edge (
    .clock     (clock),
    .reset     (reset),
    .key_press (key_press),
    .backspace (backspace),
    .fall_evt  (fall_evt),
    .bs_q      (bs_q)
  );

  logic key_sel;
  logic data_sel;
  act_e key_act;
  act_e data_act;
  logic evt_step;
  logic evt_reject;

  always_comb begin
    key_sel  = 1'b0;
    data_sel = 1'b0;
    case (mode)
      MODE_KEY:            key_sel  = fall_evt;
      MODE_DATA:           data_sel = fall_evt;
      MODE_IDLE, MODE_RUN: ;
    endcase
  end

  assign key_act  = sat_action(bs_q, key_index == '0, key_index == KEY_LIM);
  assign data_act = sat_action(bs_q, data_index == '0, data_index == DATA_LIM);

  // Clear wins over a coincident keystroke and swallows its pulse.
  assign evt_step   = ~clear & ((key_sel & (key_act == ACT_STEP)) |
                                (data_sel & (data_act == ACT_STEP)));
  assign evt_reject = ~clear & ((key_sel & (key_act == ACT_REJECT)) |
                                (data_sel & (data_act == ACT_REJECT)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_index  <= '0;
      data_index <= '0;
    end else if (clear) begin
      key_index  <= '0;
      data_index <= '0;
    end else begin
      if (key_sel && key_act == ACT_STEP)
        key_index <= bs_q ? key_index - IDX_ONE : key_index + IDX_ONE;
      if (data_sel && data_act == ACT_STEP)
        data_index <= bs_q ? data_index - IDX_ONE : data_index + IDX_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step   <= 1'b0;
      reject <= 1'b0;
    end else begin
      step   <= evt_step;
      reject <= evt_reject;
    end
  end

  assign key_full   = (key_index == KEY_LIM);
  assign data_full  = (data_index == DATA_LIM);
  assign data_empty = (data_index == '0);

endmodule
